// File: rtl/avalon_input_capture_pkg.sv
// avalon_input_capture_pkg: register offsets and EDGE_CFG bit indices
package avalon_input_capture_pkg;
   localparam logic [1:0] ADDR_DATA         = 2'd0;
   localparam logic [1:0] ADDR_IRQ_MASK     = 2'd1;
   localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd2;
   localparam logic [1:0] ADDR_EDGE_CFG     = 2'd3;
   localparam int CFG_RISE = 0;
   localparam int CFG_FALL = 1;
endpackage

// File: rtl/avalon_input_capture_if.sv
// avalon_input_capture_if: Avalon-MM slave bus bundle
interface avalon_input_capture_if;
   logic [1:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata);
   modport slave (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata);
endinterface

// File: rtl/avalon_input_capture_debounce_bit.sv
// debounce_bit: two-flop synchronizer followed by a stable-count debounce filter
module debounce_bit #(
   parameter int   DEBOUNCE_CYCLES = 250000,
   parameter int   CNT_W           = 18,
   parameter logic INIT            = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level_out
);
   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         sync      <= {2{INIT}};
         level_out <= INIT;
         cnt       <= '0;
      end else begin
         sync <= {sync[0], din};
         if (sync[1] == level_out) cnt <= '0;
         else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_out <= sync[1];
            cnt       <= '0;
         end else cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/avalon_input_capture.sv
// avalon_input_capture: debounced inputs with edge capture and maskable IRQ on Avalon-MM
module avalon_input_capture #(
   parameter int               WIDTH           = 14,
   parameter int               DEBOUNCE_CYCLES = 250000,
   parameter int               CNT_W           = 18,
   parameter logic [WIDTH-1:0] INIT_VALUE      = 14'h000F
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       pins_in,
   avalon_input_capture_if.slave  avs,
   output logic                   irq
);
   import avalon_input_capture_pkg::*;
   logic [WIDTH-1:0] level, level_d, mask, capture, evt, w1c;
   logic [1:0]       cfg;
   logic [31:0]      rd_mux;
   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .INIT(INIT_VALUE[i])) u_db (
         .clk(clk), .reset(reset), .din(pins_in[i]), .level_out(level[i]));
   end
   always_comb begin
      evt = (level & ~level_d & {WIDTH{cfg[CFG_RISE]}}) | (~level & level_d & {WIDTH{cfg[CFG_FALL]}});
      w1c = (avs.avs_write && avs.avs_address == ADDR_EDGE_CAPTURE) ? avs.avs_writedata[WIDTH-1:0] : '0;
      rd_mux = avs.avs_address == ADDR_DATA     ? 32'(level) :
               avs.avs_address == ADDR_IRQ_MASK ? 32'(mask) :
               avs.avs_address == ADDR_EDGE_CFG ? 32'(cfg) : 32'(capture);
   end
   // level_d reloads with INIT_VALUE too, so reset never fabricates an edge
   always_ff @(posedge clk) begin
      if (reset) begin
         level_d          <= INIT_VALUE;
         mask             <= '0;
         capture          <= '0;
         cfg              <= 2'b11;
         irq              <= 1'b0;
         avs.avs_readdata <= '0;
      end else begin
         level_d <= level;
         capture <= (capture & ~w1c) | evt;
         irq     <= |(capture & mask);
         if (avs.avs_write && avs.avs_address == ADDR_IRQ_MASK) mask <= avs.avs_writedata[WIDTH-1:0];
         if (avs.avs_write && avs.avs_address == ADDR_EDGE_CFG) cfg <= avs.avs_writedata[1:0];
         if (avs.avs_read) avs.avs_readdata <= rd_mux;
      end
   end
endmodule

// File: tb/tb_avalon_input_capture.sv
// tb_avalon_input_capture: scoreboard-checked bench with DEBOUNCE_CYCLES = 4
module tb_avalon_input_capture;
   import avalon_input_capture_pkg::*;
   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [13:0] pins_in = 14'h000F;
   logic        irq;
   logic        rd_q = 1'b0;
   int          n_run = 0;
   int          n_fail = 0;
   exp_t        sb[$];
   exp_t        e;
   avalon_input_capture_if bus();
   avalon_input_capture #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .pins_in(pins_in), .avs(bus), .irq(irq));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask
   always @(posedge clk) rd_q <= bus.avs_read;
   always @(negedge clk)
      if (rd_q) begin
         if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            check(e.tag, bus.avs_readdata, e.exp);
         end
      end
   task automatic bus_cycle(input logic [1:0] a, input logic rd, input logic wr,
                            input logic [31:0] wd, input logic [31:0] exp, input string tag);
      bus.avs_address   = a;
      bus.avs_read      = rd;
      bus.avs_write     = wr;
      bus.avs_writedata = wd;
      if (rd) sb.push_back('{tag, exp});
      @(negedge clk);
      bus.avs_read  = 1'b0;
      bus.avs_write = 1'b0;
   endtask
   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      bus_cycle(a, 1'b1, 1'b0, 32'd0, exp, tag);
   endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] wd);
      bus_cycle(a, 1'b0, 1'b1, wd, 32'd0, "");
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   initial begin
      bus.avs_address = '0;
      bus.avs_read = 1'b0;
      bus.avs_write = 1'b0;
      bus.avs_writedata = '0;
      idle(3);
      check("rst_readdata", bus.avs_readdata, 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      rd(ADDR_DATA, 32'hF, "rst_data");
      rd(ADDR_IRQ_MASK, 32'h0, "rst_mask");
      rd(ADDR_EDGE_CAPTURE, 32'h0, "rst_cap");
      rd(ADDR_EDGE_CFG, 32'h3, "rst_cfg");
      idle(1);
      check("rst_irq_idle", 32'(irq), 32'd0);
      // 3-cycle glitch on bit5 must be filtered out
      pins_in[5] = 1'b1;
      idle(3);
      pins_in[5] = 1'b0;
      idle(8);
      rd(ADDR_DATA, 32'hF, "glitch_data");
      rd(ADDR_EDGE_CAPTURE, 32'h0, "glitch_cap");
      check("glitch_irq", 32'(irq), 32'd0);
      // simultaneous read+write returns the pre-write value
      bus_cycle(ADDR_IRQ_MASK, 1'b1, 1'b1, 32'h20, 32'h0, "rw_pre_mask");
      rd(ADDR_IRQ_MASK, 32'h20, "mask_written");
      idle(1);
      // hold bit5: level visible at edge 6, irq at edge 8
      pins_in[5] = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         rd(ADDR_DATA, j >= 7 ? 32'h2F : 32'hF, $sformatf("settle_data_%0d", j));
         check($sformatf("settle_irq_%0d", j), 32'(irq), j >= 8 ? 32'd1 : 32'd0);
      end
      rd(ADDR_EDGE_CAPTURE, 32'h20, "cap_rise");
      wr(ADDR_EDGE_CAPTURE, 32'h20);
      check("w1c_irq_hold", 32'(irq), 32'd1);
      idle(1);
      check("w1c_irq_drop", 32'(irq), 32'd0);
      rd(ADDR_EDGE_CAPTURE, 32'h0, "w1c_cap");
      // W1C lands on the same edge that captures the bit5 fall
      pins_in[5] = 1'b0;
      idle(6);
      wr(ADDR_EDGE_CAPTURE, 32'h20);
      idle(1);
      check("set_wins_irq", 32'(irq), 32'd1);
      rd(ADDR_EDGE_CAPTURE, 32'h20, "set_wins_cap");
      rd(ADDR_DATA, 32'hF, "fall5_data");
      wr(ADDR_EDGE_CAPTURE, 32'h20);
      idle(1);
      check("clear2_irq", 32'(irq), 32'd0);
      // falling-only configuration on KEY0
      wr(ADDR_EDGE_CFG, 32'h2);
      rd(ADDR_EDGE_CFG, 32'h2, "cfg_fall");
      pins_in[0] = 1'b0;
      idle(8);
      rd(ADDR_EDGE_CAPTURE, 32'h1, "fall_cap");
      rd(ADDR_DATA, 32'hE, "fall_data");
      wr(ADDR_EDGE_CAPTURE, 32'h1);
      pins_in[0] = 1'b1;
      idle(8);
      rd(ADDR_EDGE_CAPTURE, 32'h0, "rise_ignored");
      rd(ADDR_DATA, 32'hF, "rise_data");
      check("fall_irq", 32'(irq), 32'd0);
      idle(2);
      // reset while bit3 is two counts into debounce
      pins_in[3] = 1'b0;
      idle(4);
      reset = 1'b1;
      idle(1);
      check("mid_rst_readdata", bus.avs_readdata, 32'd0);
      check("mid_rst_irq", 32'(irq), 32'd0);
      reset = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         if (j == 1) rd(ADDR_EDGE_CAPTURE, 32'h0, "mid_rst_cap");
         else rd(ADDR_DATA, j >= 7 ? 32'h7 : 32'hF, $sformatf("resettle_data_%0d", j));
         check($sformatf("resettle_irq_%0d", j), 32'(irq), 32'd0);
      end
      rd(ADDR_EDGE_CAPTURE, 32'h8, "resettle_cap");
      rd(ADDR_EDGE_CFG, 32'h3, "resettle_cfg");
      rd(ADDR_IRQ_MASK, 32'h0, "resettle_mask");
      idle(2);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
